cr_huf_comp_is_sched: RTL

Two-requester frame scheduler in front of the Huffman-compressor symbol-frequency counter (the `is_counter` stage). It arbitrates between two symbol-collector lanes and grants the counter to one lane for a whole frame, from its first beat through its end-of-block beat. It then holds off further traffic until the counter reports the frame done, which it must because the counter discards beats while busy. On completion it reports frame ownership and per-frame statistics.

---
 rtl/cr_huf_comp_is_sched.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cr_huf_comp_is_sched.sv
`default_nettype none
`timescale 1ns/1ps

`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

//============================================================================
// Module   : cr_huf_comp_is_sched (plus cr_huf_comp_is_sched_pkg)
// Purpose  : Two-requester frame scheduler in front of the Huffman symbol
//            frequency counter. Grants the counter to one collector lane for
//            a whole frame, waits for the counter to finish that frame, then
//            reports owner / beat count / symbol total for it.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            r0_*/r1_*               - requester beat (vld/sym/cnt/meta/seq/eob)
//            r0_rd/r1_rd             - beat accepted from that requester
//            sc_is_*                 - registered beat towards the counter
//            is_sc_rd, cnt_eob       - counter ready / counter frame done
//            done_vld/owner/beats/syms - one-cycle per-frame completion report
//            busy                    - scheduler not idle
// Revision : 1.0 - initial release
//============================================================================

package cr_huf_comp_is_sched_pkg;
    typedef enum logic [1:0] {
        MIDDLE        = 2'd0,
        EOB           = 2'd1,
        PASS_THRU     = 2'd2,
        PASS_THRU_EOB = 2'd3
    } e_pipe_eob;
endpackage

module cr_huf_comp_is_sched
    import cr_huf_comp_is_sched_pkg::*;
#(
    parameter int DAT_WIDTH   = 10,
    parameter int CNT_WIDTH   = 3,
    parameter int CNTRL_WIDTH = 1,
    parameter int SEQID_WIDTH = `CREOLE_HC_SEQID_WIDTH,
    parameter int SUM_WIDTH   = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               r0_vld,
    input  logic [4*DAT_WIDTH-1:0]   r0_sym,
    input  logic [4*CNT_WIDTH-1:0]   r0_cnt,
    input  logic [CNTRL_WIDTH-1:0]   r0_meta,
    input  logic [SEQID_WIDTH-1:0]   r0_seq_id,
    input  e_pipe_eob                r0_eob,
    output logic                     r0_rd,
    input  logic [3:0]               r1_vld,
    input  logic [4*DAT_WIDTH-1:0]   r1_sym,
    input  logic [4*CNT_WIDTH-1:0]   r1_cnt,
    input  logic [CNTRL_WIDTH-1:0]   r1_meta,
    input  logic [SEQID_WIDTH-1:0]   r1_seq_id,
    input  e_pipe_eob                r1_eob,
    output logic                     r1_rd,
    output logic [3:0]               sc_is_vld,
    output logic [DAT_WIDTH-1:0]     sc_is_sym0,
    output logic [DAT_WIDTH-1:0]     sc_is_sym1,
    output logic [DAT_WIDTH-1:0]     sc_is_sym2,
    output logic [DAT_WIDTH-1:0]     sc_is_sym3,
    output logic [CNT_WIDTH-1:0]     sc_is_cnt0,
    output logic [CNT_WIDTH-1:0]     sc_is_cnt1,
    output logic [CNT_WIDTH-1:0]     sc_is_cnt2,
    output logic [CNT_WIDTH-1:0]     sc_is_cnt3,
    output logic [CNTRL_WIDTH-1:0]   sc_is_meta,
    output logic [SEQID_WIDTH-1:0]   sc_is_seq_id,
    output e_pipe_eob                sc_is_eob,
    input  logic                     is_sc_rd,
    input  e_pipe_eob                cnt_eob,
    output logic                     done_vld,
    output logic                     done_owner,
    output logic [15:0]              done_beats,
    output logic [SUM_WIDTH-1:0]     done_syms,
    output logic                     busy
);

    localparam logic [1:0]  c_ST_IDLE    = 2'd0;
    localparam logic [1:0]  c_ST_XFER    = 2'd1;
    localparam logic [1:0]  c_ST_WAIT    = 2'd2;
    localparam int          c_BSUM_WIDTH = CNT_WIDTH + 2;   // sum of four lane counts
    localparam logic [15:0] c_BEAT_MAX   = 16'hFFFF;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic                    r_grant;
    logic                    r_rr_ptr;
    logic [15:0]             r_beat_cnt;
    logic [SUM_WIDTH-1:0]    r_sym_sum;

    logic                    w_req0;
    logic                    w_req1;
    logic                    w_grant_nxt;
    logic                    w_acc;
    logic                    w_frame_end;
    logic                    w_cnt_done;
    logic [3:0]              w_vld;
    logic [4*DAT_WIDTH-1:0]  w_sym;
    logic [4*CNT_WIDTH-1:0]  w_cnt;
    logic [CNTRL_WIDTH-1:0]  w_meta;
    logic [SEQID_WIDTH-1:0]  w_seq_id;
    e_pipe_eob               w_eob;
    logic [c_BSUM_WIDTH-1:0] w_beat_sum;
    logic [SUM_WIDTH:0]      w_sym_add;

    assign w_req0 = |r0_vld;
    assign w_req1 = |r1_vld;

    // Beat fields from whichever requester currently owns the counter
    assign w_vld    = r_grant ? r1_vld    : r0_vld;
    assign w_sym    = r_grant ? r1_sym    : r0_sym;
    assign w_cnt    = r_grant ? r1_cnt    : r0_cnt;
    assign w_meta   = r_grant ? r1_meta   : r0_meta;
    assign w_seq_id = r_grant ? r1_seq_id : r0_seq_id;
    assign w_eob    = r_grant ? r1_eob    : r0_eob;

    assign w_acc       = r0_rd | r1_rd;
    assign w_frame_end = w_acc && (w_eob != MIDDLE);
    // A counter eob outside WAIT is a protocol error and is deliberately ignored
    assign w_cnt_done  = (r_state == c_ST_WAIT) && (cnt_eob != MIDDLE);

    // Round-robin pointer only breaks ties; a lone requester always wins
    assign w_grant_nxt = (w_req0 && w_req1) ? r_rr_ptr : w_req1;

    always_comb begin
        w_beat_sum = '0;
        for (int k = 0; k < 4; k++) begin
            if (w_vld[k]) begin
                w_beat_sum = w_beat_sum + {2'b00, w_cnt[k*CNT_WIDTH +: CNT_WIDTH]};
            end
        end
    end

    // One extra bit catches the carry used for saturation
    assign w_sym_add = {1'b0, r_sym_sum} + {{(SUM_WIDTH + 1 - c_BSUM_WIDTH){1'b0}}, w_beat_sum};

    //------------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //------------------------------------------------------------------------
    // FSM: next state
    //------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_req0 || w_req1) w_state_nxt = c_ST_XFER;
            c_ST_XFER: if (w_frame_end)      w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: if (w_cnt_done)       w_state_nxt = c_ST_IDLE;
            default:                         w_state_nxt = c_ST_IDLE;
        endcase
    end

    //------------------------------------------------------------------------
    // FSM: outputs. Only the granted requester is ever accepted, even when it
    // has nothing valid and the other one is waiting.
    //------------------------------------------------------------------------
    always_comb begin
        r0_rd = 1'b0;
        r1_rd = 1'b0;
        busy  = (r_state != c_ST_IDLE);
        if ((r_state == c_ST_XFER) && is_sc_rd) begin
            r0_rd = ~r_grant & w_req0;
            r1_rd =  r_grant & w_req1;
        end
    end

    //------------------------------------------------------------------------
    // Grant, round-robin pointer and per-frame statistics
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant    <= 1'b0;
            r_rr_ptr   <= 1'b0;
            r_beat_cnt <= '0;
            r_sym_sum  <= '0;
        end else begin
            if ((r_state == c_ST_IDLE) && (w_req0 || w_req1)) begin
                r_grant <= w_grant_nxt;
            end
            if (w_frame_end) begin
                r_rr_ptr <= ~r_grant;
            end
            if (w_cnt_done) begin
                r_beat_cnt <= '0;
                r_sym_sum  <= '0;
            end else if (w_acc) begin
                if (r_beat_cnt != c_BEAT_MAX) begin
                    r_beat_cnt <= r_beat_cnt + 16'd1;
                end
                r_sym_sum <= w_sym_add[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : w_sym_add[SUM_WIDTH-1:0];
            end
        end
    end

    //------------------------------------------------------------------------
    // Registered beat towards the counter; payload holds between beats
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_is_vld    <= '0;
            sc_is_sym0   <= '0;
            sc_is_sym1   <= '0;
            sc_is_sym2   <= '0;
            sc_is_sym3   <= '0;
            sc_is_cnt0   <= '0;
            sc_is_cnt1   <= '0;
            sc_is_cnt2   <= '0;
            sc_is_cnt3   <= '0;
            sc_is_meta   <= '0;
            sc_is_seq_id <= '0;
            sc_is_eob    <= MIDDLE;
        end else begin
            sc_is_vld <= w_acc ? w_vld : 4'd0;
            sc_is_eob <= w_acc ? w_eob : MIDDLE;
            if (w_acc) begin
                sc_is_sym0   <= w_sym[0*DAT_WIDTH +: DAT_WIDTH];
                sc_is_sym1   <= w_sym[1*DAT_WIDTH +: DAT_WIDTH];
                sc_is_sym2   <= w_sym[2*DAT_WIDTH +: DAT_WIDTH];
                sc_is_sym3   <= w_sym[3*DAT_WIDTH +: DAT_WIDTH];
                sc_is_cnt0   <= w_cnt[0*CNT_WIDTH +: CNT_WIDTH];
                sc_is_cnt1   <= w_cnt[1*CNT_WIDTH +: CNT_WIDTH];
                sc_is_cnt2   <= w_cnt[2*CNT_WIDTH +: CNT_WIDTH];
                sc_is_cnt3   <= w_cnt[3*CNT_WIDTH +: CNT_WIDTH];
                sc_is_meta   <= w_meta;
                sc_is_seq_id <= w_seq_id;
            end
        end
    end

    //------------------------------------------------------------------------
    // Frame-complete report, one cycle after the counter signals done
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            done_vld   <= 1'b0;
            done_owner <= 1'b0;
            done_beats <= '0;
            done_syms  <= '0;
        end else begin
            done_vld <= w_cnt_done;
            if (w_cnt_done) begin
                done_owner <= r_grant;
                done_beats <= r_beat_cnt;
                done_syms  <= r_sym_sum;
            end
        end
    end

endmodule

`default_nettype wire
